// File: rtl/rv_skid_ready_if.sv
// rv_if: ready/valid handshake bundle with payload, plus views for slice ports
interface rv_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport ingress   (input valid, input data, output ready);
    modport egress_rv (output valid, input ready);
endinterface

// File: rtl/rv_skid_ready.sv
// rv_skid_ready: ready-path register slice with a two-entry skid store
module rv_skid_ready #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    rv_if.ingress             rv_i,
    rv_if.egress_rv           rv_e,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occ
);
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] main_q, main_n, skid_q, skid_n;
    logic              ready_q;
    logic              in_fire, out_fire;

    assign in_fire  = rv_i.valid & ready_q;
    assign out_fire = (state != EMPTY) & rv_e.ready;

    assign rv_i.ready = ready_q;
    assign rv_e.valid = (state != EMPTY);
    assign data_o     = main_q;
    assign occ        = (state == FULL) ? 2'd2 : (state == ONE) ? 2'd1 : 2'd0;

    // next occupancy and word movement; the skid word always refills main first
    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_n = ONE;
                    main_n  = rv_i.data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_n = rv_i.data;
                end else if (in_fire) begin
                    state_n = FULL;
                    skid_n  = rv_i.data;
                end else if (out_fire) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_n = ONE;
                    main_n  = skid_q;
                    skid_n  = '0;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    // state, payload and registered ingress ready (no path from rv_e.ready)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_n;
            main_q  <= main_n;
            skid_q  <= skid_n;
            ready_q <= (state_n != FULL);
        end
    end
endmodule

// File: tb/tb_rv_skid_ready.sv
// tb_rv_skid_ready: directed vectors, corner sequences and scoreboard stress
module tb_rv_skid_ready;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_o;
    logic [1:0] occ;
    int         checks = 0;
    int         failures = 0;

    rv_if #(.DATA_W(8)) in_if ();
    rv_if #(.DATA_W(8)) out_if ();

    assign out_if.data = data_o;

    rv_skid_ready #(.DATA_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .rv_i   (in_if.ingress),
        .rv_e   (out_if.egress_rv),
        .data_o (data_o),
        .occ    (occ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       ev;
        logic [7:0] ed;
        logic [1:0] eocc;
        logic       erdy;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        in_if.valid  = v;
        in_if.data   = d;
        out_if.ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic       inf, outf, rdy0;
        tbl = '{
            '{0, 8'h00, 1, 0, 8'h00, 0, 1},
            '{1, 8'h01, 0, 1, 8'h01, 1, 1},
            '{1, 8'hA0, 1, 1, 8'hA0, 1, 1},
            '{1, 8'hA1, 0, 1, 8'hA0, 2, 0},
            '{1, 8'hA2, 0, 1, 8'hA0, 2, 0},
            '{1, 8'hA2, 1, 1, 8'hA1, 1, 1},
            '{1, 8'hA2, 0, 1, 8'hA1, 2, 0},
            '{0, 8'h00, 1, 1, 8'hA2, 1, 1},
            '{0, 8'h00, 1, 0, 8'h00, 0, 1},
            '{1, 8'h5A, 1, 1, 8'h5A, 1, 1},
            '{0, 8'h00, 0, 1, 8'h5A, 1, 1},
            '{0, 8'h00, 1, 0, 8'h00, 0, 1},
            '{1, 8'h33, 0, 1, 8'h33, 1, 1},
            '{1, 8'h44, 0, 1, 8'h33, 2, 0},
            '{1, 8'h55, 1, 1, 8'h44, 1, 1},
            '{1, 8'h55, 1, 1, 8'h55, 1, 1},
            '{0, 8'h00, 1, 0, 8'h00, 0, 1}
        };
        rst = 1'b0;
        in_if.valid = 1'b0;
        in_if.data = '0;
        out_if.ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(out_if.valid), 0);
        chk("rst_occ", 32'(occ), 0);
        chk("rst_ready", 32'(in_if.ready), 0);
        chk("rst_data", 32'(data_o), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("rel_ready_before_edge", 32'(in_if.ready), 0);
        @(posedge clk);
        #1;
        chk("rel_ready_after_edge", 32'(in_if.ready), 1);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r);
            chk($sformatf("vec%0d_valid", i), 32'(out_if.valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_occ", i), 32'(occ), 32'(tbl[i].eocc));
            chk($sformatf("vec%0d_ready", i), 32'(in_if.ready), 32'(tbl[i].erdy));
            if (tbl[i].ev)
                chk($sformatf("vec%0d_data", i), 32'(data_o), 32'(tbl[i].ed));
        end

        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 8'(i), 1'b1);
            chk($sformatf("stream%0d_data", i), 32'(data_o), 32'(i));
            chk($sformatf("stream%0d_valid", i), 32'(out_if.valid), 1);
            chk($sformatf("stream%0d_occ", i), 32'(occ), 1);
            chk($sformatf("stream%0d_ready", i), 32'(in_if.ready), 1);
        end
        step(1'b0, 8'h00, 1'b1);
        chk("stream_drain_occ", 32'(occ), 0);

        step(1'b1, 8'h5A, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 8'h00, 1'b0);
            chk($sformatf("single%0d", i), {out_if.valid, data_o, occ, in_if.ready}, {1'b1, 8'h5A, 2'd1, 1'b1});
        end
        step(1'b0, 8'h00, 1'b1);
        chk("single_release_occ", 32'(occ), 0);
        chk("single_release_valid", 32'(out_if.valid), 0);

        step(1'b1, 8'hC1, 1'b0);
        step(1'b1, 8'hC2, 1'b0);
        chk("pre_reset_occ", 32'(occ), 2);
        in_if.valid = 1'b0;
        out_if.ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_if.valid), 0);
        chk("midrst_occ", 32'(occ), 0);
        chk("midrst_ready", 32'(in_if.ready), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_rel_ready", 32'(in_if.ready), 1);
        chk("midrst_rel_valid", 32'(out_if.valid), 0);
        step(1'b0, 8'h00, 1'b1);
        chk("midrst_no_stale", {out_if.valid, occ}, 0);

        for (int c = 0; c < 10000; c++) begin
            in_if.valid  = (c < 9990) ? 1'($urandom_range(1)) : 1'b0;
            in_if.data   = 8'($urandom);
            out_if.ready = (c < 9990) ? 1'($urandom_range(1)) : 1'b1;
            @(negedge clk);
            chk("rnd_occ", 32'(occ), 32'(q.size()));
            chk("rnd_valid", 32'(out_if.valid), 32'(q.size() != 0));
            chk("rnd_ready", 32'(in_if.ready), 32'(q.size() != 2));
            if (q.size() != 0)
                chk("rnd_data", 32'(data_o), 32'(q[0]));
            rdy0 = in_if.ready;
            out_if.ready = ~out_if.ready;
            #1;
            chk("rnd_ready_comb", 32'(in_if.ready), 32'(rdy0));
            out_if.ready = ~out_if.ready;
            #1;
            inf  = in_if.valid & in_if.ready;
            outf = out_if.valid & out_if.ready;
            @(posedge clk);
            if (outf && q.size() != 0) void'(q.pop_front());
            if (inf) q.push_back(in_if.data);
            #1;
        end
        chk("rnd_final_queue", 32'(q.size()), 0);
        chk("rnd_final_occ", 32'(occ), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
